// File: rtl/uart_loader_pkg.sv
// Shared types for the UART boot loader: FSM state encoding and error codes.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FRAMING = 2'd1;
  localparam logic [1:0] ERR_LENGTH  = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

endpackage

// File: rtl/uart_loader_word_asm.sv
// Little-endian byte-to-word assembler. The first byte lands in [7:0], the
// fourth in [31:24]. word/word_valid are presented combinationally alongside
// the fourth byte, so the owner can register the result one cycle later.
module uart_loader_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx;
  logic [23:0] low;

  assign word       = {byte_data, low};
  assign word_valid = byte_valid && (idx == 2'd3);

  // Collect the three low bytes and advance the index, which wraps 3->0 per word.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    if (rst || clear) begin
      idx <= 2'd0;
      low <= 24'd0;
    end else if (byte_valid) begin
      case (idx)
        2'd0:    low[7:0]   <= byte_data;
        2'd1:    low[15:8]  <= byte_data;
        2'd2:    low[23:16] <= byte_data;
        default: low        <= low;
      endcase
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: parses a 4-byte little-endian word-count header, then writes
// that many assembled words to instruction memory starting at BASE_ADDR.
// Optional feature macro: UART_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte over the payload, checked before done is raised.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int                ADDR_W    = 15,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  // Largest legal word count: the full address space.
  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

  state_t            state;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   wc_next;
  logic              in_asm;
  logic              in_busy;
  logic              abort;
  logic              start_ok;
  logic [31:0]       asm_word;
  logic              asm_valid;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign in_asm   = (state == ST_LEN) || (state == ST_DATA);
  assign in_busy  = in_asm || (state == ST_CSUM);
  assign abort    = rx_valid && rx_ferr && in_busy;
  assign start_ok = start && !in_busy;
  assign wc_next  = word_count + (ADDR_W+1)'(1);

  // Header and payload words share one assembler; it is flushed on start and abort.
  uart_loader_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok || abort),
    .byte_valid (in_asm && rx_valid && !rx_ferr),
    .byte_data  (rx_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  // Load sequencer: state, write port, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      word_count <= '0;
      n_words    <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_LEN;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            word_count <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
          end
        end

        ST_LEN: begin
          if (abort) begin
            state    <= ST_ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_FRAMING;
          end else if (asm_valid) begin
            if (asm_word == 32'd0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if ({1'b0, asm_word} > MAX_WORDS) begin
              state    <= ST_ERR;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_LENGTH;
            end else begin
              state   <= ST_DATA;
              n_words <= asm_word[ADDR_W:0];
            end
          end
        end

        ST_DATA: begin
          if (abort) begin
            state    <= ST_ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_FRAMING;
          end else begin
`ifdef UART_LOADER_CHECKSUM_EN
            if (rx_valid) csum <= csum ^ rx_data;
`endif
            if (asm_valid) begin
              mem_we     <= 1'b1;
              mem_addr   <= BASE_ADDR + word_count[ADDR_W-1:0];
              mem_wdata  <= asm_word;
              word_count <= wc_next;
              if (wc_next == n_words) begin
`ifdef UART_LOADER_CHECKSUM_EN
                state <= ST_CSUM;
`else
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
`endif
              end
            end
          end
        end

`ifdef UART_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (abort) begin
            state    <= ST_ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_FRAMING;
          end else if (rx_valid) begin
            busy <= 1'b0;
            if (rx_data == csum) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_ERR;
              err      <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: reset values, hand-written corner
// sequences, a table of load scenarios and randomized loads, all compared
// against a byte-stream reference model. Honours UART_LOADER_CHECKSUM_EN.
module tb_uart_loader;

  localparam int                ADDR_W = 15;
  localparam logic [ADDR_W-1:0] BASE   = '0;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [ADDR_W:0]   wc;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    logic [31:0] n;
    int          ferr_at;
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;
    int          exp_wc;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst, start, rx_valid, rx_ferr;
  logic [7:0]        rx_data;
  logic              mem_we, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   word_count;

  int n_cmp = 0;
  int n_bad = 0;

  wr_t  wr_q[$];
  wr_t  exp_q[$];
  logic m_done, m_err, m_busy;
  logic [1:0] m_code;
  bit   need_reset = 1'b0;

  uart_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ferr    (rx_ferr),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Capture every memory write away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) wr_q.push_back('{word_count, mem_addr, mem_wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ferr);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_ferr  = ferr;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1;
    @(negedge clk);
    if (chk) begin
      check("reset flags", {mem_we, busy, done, err, err_code}, 6'd0);
      check("reset data", {mem_addr, mem_wdata, word_count}, 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Header (little-endian n) followed by random payload words and, when the
  // checksum feature is built in and the payload is complete, the XOR byte.
  function automatic bq_t make_stream(input logic [31:0] n, input int words, input bit bad_csum);
    bq_t        s;
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int i = 0; i < 4; i++) s.push_back(n[8*i +: 8]);
    for (int i = 0; i < 4 * words; i++) begin
      b = 8'($urandom);
      x ^= b;
      s.push_back(b);
    end
    if (bad_csum) x ^= 8'h01;
`ifdef UART_LOADER_CHECKSUM_EN
    if (words > 0 && 32'(words) == n) s.push_back(x);
`endif
    return s;
  endfunction

  // Reference model: interprets the byte stream as header + words (+ checksum).
  task automatic model(input bq_t s, input int ferr_at);
    logic [31:0] n;
    logic [7:0]  x;
    int          base;
    exp_q.delete();
    m_done = 1'b0; m_err = 1'b0; m_busy = 1'b1; m_code = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (i >= s.size()) return;
      if (i == ferr_at) begin m_err = 1'b1; m_code = 2'd1; m_busy = 1'b0; return; end
    end
    n = {s[3], s[2], s[1], s[0]};
    if (n == 0) begin m_done = 1'b1; m_busy = 1'b0; return; end
    if (n > 32'(1 << ADDR_W)) begin m_err = 1'b1; m_code = 2'd2; m_busy = 1'b0; return; end
    x = 8'h00;
    for (int w = 0; w < int'(n); w++) begin
      base = 4 + 4 * w;
      for (int b = 0; b < 4; b++) begin
        if (base + b >= s.size()) return;
        if (base + b == ferr_at) begin m_err = 1'b1; m_code = 2'd1; m_busy = 1'b0; return; end
        x ^= s[base + b];
      end
      exp_q.push_back('{(ADDR_W+1)'(w + 1), ADDR_W'(int'(BASE) + w),
                        {s[base+3], s[base+2], s[base+1], s[base]}});
    end
`ifdef UART_LOADER_CHECKSUM_EN
    base = 4 + 4 * int'(n);
    if (base >= s.size()) return;
    m_busy = 1'b0;
    if (base == ferr_at) begin m_err = 1'b1; m_code = 2'd1; end
    else if (s[base] == x) m_done = 1'b1;
    else begin m_err = 1'b1; m_code = 2'd3; end
`else
    m_done = 1'b1;
    m_busy = 1'b0;
`endif
  endtask

  // Feed a stream with random gaps; optionally pulse start mid-load (must be ignored).
  task automatic feed(input bq_t s, input int ferr_at, input bit inj_start);
    for (int i = 0; i < s.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (inj_start && i == 1 && ferr_at != 0) start = 1'b1;
      send_byte(s[i], (i == ferr_at) ? 1'b1 : 1'b0);
      start = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_case(input string name);
    check({name, " write count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s write%0d", name, i),
            {wr_q[i].wc, wr_q[i].addr, wr_q[i].data},
            {exp_q[i].wc, exp_q[i].addr, exp_q[i].data});
    check({name, " status"}, {done, err, busy, err_code}, {m_done, m_err, m_busy, m_code});
    check({name, " word_count"}, 64'(word_count), 64'(exp_q.size()));
  endtask

  task automatic run_case(input string name, input bq_t s, input int ferr_at);
    if (need_reset) do_reset(1'b0);
    pulse_start();
    wr_q.delete();
    feed(s, ferr_at, 1'($urandom_range(0, 1)));
    model(s, ferr_at);
    compare_case(name);
    need_reset = m_busy;
  endtask

  initial begin
    vec_t       tbl[8];
    bq_t        s;
    logic [7:0] hdr2[4]  = '{8'h02, 8'h00, 8'h00, 8'h00};
    logic [7:0] pay1[8]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] img6[8]  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [31:0] n;
    int          words;
    int          ferr_at;

    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_ferr = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    do_reset(1'b1);

    // Image of two words: exact data, address, timing of each write.
    pulse_start();
    check("busy after start", {busy, done, err}, 3'b100);
    for (int i = 0; i < 4; i++) send_byte(hdr2[i], 1'b0);
    for (int i = 0; i < 4; i++) send_byte(pay1[i], 1'b0);
    check("word0 write", {mem_we, mem_addr, mem_wdata, word_count}, {1'b1, 15'd0, 32'h44332211, 16'd1});
    for (int i = 4; i < 8; i++) send_byte(pay1[i], 1'b0);
    check("word1 write", {mem_we, mem_addr, mem_wdata, word_count}, {1'b1, 15'd1, 32'hDDCCBBAA, 16'd2});
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'h44, 1'b0);
`endif
    check("image done", {done, err, busy, err_code}, 5'b10000);

    // Zero-length header: done the cycle after the 4th byte, no writes.
    pulse_start();
    wr_q.delete();
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0);
    check("zero len pending", {busy, done}, 2'b10);
    send_byte(8'h00, 1'b0);
    check("zero len done", {mem_we, busy, done, err}, 4'b0010);
    @(negedge clk);
    check("zero len no writes", 64'(wr_q.size()), 64'd0);

    // Scenario table: fixed expectations for flags, model for the write stream.
    tbl[0] = '{32'd2,     -1, 1'b1, 1'b0, 2'd0, 2};
    tbl[1] = '{32'd0,     -1, 1'b1, 1'b0, 2'd0, 0};
    tbl[2] = '{32'd32769, -1, 1'b0, 1'b1, 2'd2, 0};
    tbl[3] = '{32'd3,      6, 1'b0, 1'b1, 2'd1, 0};
    tbl[4] = '{32'd3,     10, 1'b0, 1'b1, 2'd1, 1};
    tbl[5] = '{32'd1,      2, 1'b0, 1'b1, 2'd1, 0};
    tbl[6] = '{32'd32768,  4, 1'b0, 1'b1, 2'd1, 0};
    tbl[7] = '{32'd5,     -1, 1'b1, 1'b0, 2'd0, 5};
    for (int t = 0; t < 8; t++) begin
      words = (tbl[t].n > 32'd8) ? ((tbl[t].n > 32'd32768) ? 0 : 1) : int'(tbl[t].n);
      s = make_stream(tbl[t].n, words, 1'b0);
      run_case($sformatf("table%0d", t), s, tbl[t].ferr_at);
      check($sformatf("table%0d flags", t), {done, err, err_code}, {tbl[t].exp_done, tbl[t].exp_err, tbl[t].exp_code});
      check($sformatf("table%0d count", t), 64'(word_count), 64'(tbl[t].exp_wc));
    end

    // start coincident with rx_valid: start wins, the byte is dropped.
    if (need_reset) do_reset(1'b0);
    start = 1'b1; rx_valid = 1'b1; rx_ferr = 1'b0; rx_data = 8'h05;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    wr_q.delete();
    s = make_stream(32'd1, 1, 1'b0);
    feed(s, -1, 1'b0);
    model(s, -1);
    compare_case("start vs byte");

    // Reset mid-word, then a full image: no stale bytes, first write at BASE.
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(img6[i], 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    do_reset(1'b1);
    s.delete();
    for (int i = 0; i < 8; i++) s.push_back(img6[i]);
`ifdef UART_LOADER_CHECKSUM_EN
    s.push_back(8'h04);
`endif
    need_reset = 1'b0;
    run_case("after reset", s, -1);
    if (wr_q.size() > 0)
      check("after reset word", {wr_q[0].addr, wr_q[0].data}, {BASE, 32'h04030201});

`ifdef UART_LOADER_CHECKSUM_EN
    // Checksum: 01^02^04^08 = 0F.
    s.delete();
    s.push_back(8'h01); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00);
    s.push_back(8'h01); s.push_back(8'h02); s.push_back(8'h04); s.push_back(8'h08);
    s.push_back(8'h0F);
    run_case("csum good", s, -1);
    check("csum good flags", {done, err, err_code}, 4'b1000);
    void'(s.pop_back());
    s.push_back(8'h0E);
    run_case("csum bad", s, -1);
    check("csum bad flags", {done, err, err_code}, 4'b0111);
`endif

    // Randomized loads: lengths, framing errors, bad checksums, truncation.
    for (int r = 0; r < 30; r++) begin
      n = 32'($urandom_range(0, 6));
      words = int'(n);
      if ($urandom_range(0, 9) == 0) begin
        n = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd32769 + 32'($urandom_range(0, 100));
        words = 0;
      end
      s = make_stream(n, words, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 9) == 0 && s.size() > 1) void'(s.pop_back());
      ferr_at = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, s.size() - 1)) : -1;
      run_case($sformatf("rand%0d", r), s, ferr_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
